calc_port_scheduler: RTL and testbench

- Front-end controller for the shared calculator ALU.
- Accepts two-cycle requests on four requester ports and holds them in per-port tag queues.
- Round-robin arbitrates issue to a single ALU with a valid/ready handshake.
- Routes ALU results back to the originating port's resp/data/tag outputs.
- Slice i of every packed bus corresponds to requester port i+1.

---
 rtl/calc_port_scheduler_if.sv | 41 ++++
 rtl/calc_port_scheduler.sv | 235 +++++++++++++++++++++++
 tb/tb_calc_port_scheduler.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/calc_port_scheduler_if.sv
// Requester, ALU issue and ALU response bundle for the calculator port scheduler.
// master = requesters/ALU side, slave = scheduler.
interface calc_port_scheduler_if #(
    parameter int NPORT  = 4,
    parameter int CMD_W  = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 2
);
    logic [NPORT*CMD_W-1:0]  req_cmd_in;
    logic [NPORT*DATA_W-1:0] req_data_in;
    logic [NPORT*TAG_W-1:0]  req_tag_in;
    logic                    alu_valid;
    logic                    alu_ready;
    logic [CMD_W-1:0]        alu_cmd;
    logic [DATA_W-1:0]       alu_op1;
    logic [DATA_W-1:0]       alu_op2;
    logic [1:0]              alu_port;
    logic [TAG_W-1:0]        alu_tag;
    logic                    alu_rsp_valid;
    logic [1:0]              alu_rsp;
    logic [DATA_W-1:0]       alu_rsp_data;
    logic [1:0]              alu_rsp_port;
    logic [TAG_W-1:0]        alu_rsp_tag;
    logic [NPORT*2-1:0]      out_resp;
    logic [NPORT*DATA_W-1:0] out_data;
    logic [NPORT*TAG_W-1:0]  out_tag;

    modport master (
        output req_cmd_in, req_data_in, req_tag_in, alu_ready,
               alu_rsp_valid, alu_rsp, alu_rsp_data, alu_rsp_port, alu_rsp_tag,
        input  alu_valid, alu_cmd, alu_op1, alu_op2, alu_port, alu_tag,
               out_resp, out_data, out_tag
    );

    modport slave (
        input  req_cmd_in, req_data_in, req_tag_in, alu_ready,
               alu_rsp_valid, alu_rsp, alu_rsp_data, alu_rsp_port, alu_rsp_tag,
        output alu_valid, alu_cmd, alu_op1, alu_op2, alu_port, alu_tag,
               out_resp, out_data, out_tag
    );
endinterface

// File: rtl/calc_port_scheduler.sv
// Front-end for the shared calculator ALU: per-port two-cycle capture, tag queues,
// round-robin issue through a registered valid/ready stage, and response routing.
module calc_port_scheduler #(
    parameter int NPORT  = 4,
    parameter int CMD_W  = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 2
) (
    input  logic                 PClk,
    input  logic                 reset,
    calc_port_scheduler_if.slave bus
);
    localparam int DEPTH   = 2**TAG_W;
    localparam int PORT_W  = 2;
    localparam int ENTRY_W = CMD_W + 2*DATA_W + TAG_W;

    typedef enum logic {S_IDLE = 1'b0, S_OPND2 = 1'b1} cap_state_e;

    function automatic logic is_legal_cmd(input logic [CMD_W-1:0] cmd);
        logic ok;
        case (cmd)
            CMD_W'(1), CMD_W'(2), CMD_W'(5), CMD_W'(6): ok = 1'b1;
            default:                                    ok = 1'b0;
        endcase
        return ok;
    endfunction

    cap_state_e              r_state     [NPORT];
    cap_state_e              w_state_nxt [NPORT];
    logic [CMD_W-1:0]        r_cap_cmd   [NPORT];
    logic [DATA_W-1:0]       r_cap_op1   [NPORT];
    logic [TAG_W-1:0]        r_cap_tag   [NPORT];
    logic [ENTRY_W-1:0]      r_fifo      [NPORT][DEPTH];
    logic [TAG_W-1:0]        r_wr_ptr    [NPORT];
    logic [TAG_W-1:0]        r_rd_ptr    [NPORT];
    logic [TAG_W:0]          r_count     [NPORT];
    logic [DEPTH-1:0]        r_busy      [NPORT];
    logic [NPORT-1:0]        r_err_pend;
    logic [TAG_W-1:0]        r_err_tag   [NPORT];
    logic [NPORT*2-1:0]      r_out_resp;
    logic [NPORT*DATA_W-1:0] r_out_data;
    logic [NPORT*TAG_W-1:0]  r_out_tag;

    logic                    r_alu_valid;
    logic [CMD_W-1:0]        r_alu_cmd;
    logic [DATA_W-1:0]       r_alu_op1;
    logic [DATA_W-1:0]       r_alu_op2;
    logic [PORT_W-1:0]       r_alu_port;
    logic [TAG_W-1:0]        r_alu_tag;
    logic [PORT_W-1:0]       r_rr;

    logic [NPORT-1:0]        w_capture;
    logic [NPORT-1:0]        w_push;
    logic [NPORT-1:0]        w_err;
    logic [NPORT-1:0]        w_rsp_hit;
    logic [NPORT-1:0]        w_nonempty;
    logic [NPORT-1:0]        w_pop;
    logic [DEPTH-1:0]        w_clr_mask   [NPORT];
    logic [ENTRY_W-1:0]      w_push_entry [NPORT];
    logic [ENTRY_W-1:0]      w_head       [NPORT];
    logic                    w_load;
    logic                    w_grant_vld;
    logic [PORT_W-1:0]       w_grant_idx;
    logic [ENTRY_W-1:0]      w_grant_entry;
    int                      w_scan;

    // Capture FSM state register
    always_ff @(posedge PClk) begin
        for (int p = 0; p < NPORT; p++) begin
            if (!reset) begin
                r_state[p] <= S_IDLE;
            end else begin
                r_state[p] <= w_state_nxt[p];
            end
        end
    end

    // Capture FSM next state; a held error response blocks a new capture
    always_comb begin
        for (int p = 0; p < NPORT; p++) begin
            w_state_nxt[p] = r_state[p];
            w_capture[p]   = 1'b0;
            case (r_state[p])
                S_IDLE: begin
                    if ((bus.req_cmd_in[p*CMD_W +: CMD_W] != {CMD_W{1'b0}}) && !r_err_pend[p]) begin
                        w_capture[p]   = 1'b1;
                        w_state_nxt[p] = S_OPND2;
                    end else begin
                        w_state_nxt[p] = S_IDLE;
                    end
                end
                S_OPND2: w_state_nxt[p] = S_IDLE;
                default: w_state_nxt[p] = S_IDLE;
            endcase
        end
    end

    // Per-port validation, tag release and queue head (empty queue bypasses the incoming request)
    always_comb begin
        for (int p = 0; p < NPORT; p++) begin
            w_rsp_hit[p]    = bus.alu_rsp_valid && (bus.alu_rsp_port == PORT_W'(p)) &&
                              r_busy[p][bus.alu_rsp_tag];
            w_clr_mask[p]   = w_rsp_hit[p] ? (DEPTH'(1) << bus.alu_rsp_tag) : {DEPTH{1'b0}};
            w_push[p]       = (r_state[p] == S_OPND2) && is_legal_cmd(r_cap_cmd[p]) &&
                              !(r_busy[p][r_cap_tag[p]] && !w_clr_mask[p][r_cap_tag[p]]);
            w_err[p]        = (r_state[p] == S_OPND2) && !w_push[p];
            w_push_entry[p] = {r_cap_cmd[p], r_cap_op1[p],
                               bus.req_data_in[p*DATA_W +: DATA_W], r_cap_tag[p]};
            w_nonempty[p]   = (r_count[p] != (TAG_W+1)'(0)) || w_push[p];
            w_head[p]       = (r_count[p] != (TAG_W+1)'(0)) ? r_fifo[p][r_rd_ptr[p]] : w_push_entry[p];
        end
    end

    // Round-robin search from the pointer; grant only when the issue stage can load
    always_comb begin
        w_load      = !r_alu_valid || bus.alu_ready;
        w_grant_vld = 1'b0;
        w_grant_idx = {PORT_W{1'b0}};
        w_scan      = 0;
        for (int k = 0; k < NPORT; k++) begin
            w_scan = int'(r_rr) + k;
            w_scan = (w_scan >= NPORT) ? (w_scan - NPORT) : w_scan;
            if (!w_grant_vld && w_nonempty[w_scan]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = PORT_W'(w_scan);
            end else begin
                w_grant_vld = w_grant_vld;
            end
        end
        w_pop = {NPORT{1'b0}};
        if (w_load && w_grant_vld) begin
            w_pop[w_grant_idx] = 1'b1;
        end else begin
            w_pop = {NPORT{1'b0}};
        end
        w_grant_entry = w_head[w_grant_idx];
    end

    // Per-port capture latches, queue, busy bitmap and response outputs
    always_ff @(posedge PClk) begin
        for (int p = 0; p < NPORT; p++) begin
            if (!reset) begin
                r_cap_cmd[p]                    <= {CMD_W{1'b0}};
                r_cap_op1[p]                    <= {DATA_W{1'b0}};
                r_cap_tag[p]                    <= {TAG_W{1'b0}};
                r_wr_ptr[p]                     <= {TAG_W{1'b0}};
                r_rd_ptr[p]                     <= {TAG_W{1'b0}};
                r_count[p]                      <= {(TAG_W+1){1'b0}};
                r_busy[p]                       <= {DEPTH{1'b0}};
                r_err_pend[p]                   <= 1'b0;
                r_err_tag[p]                    <= {TAG_W{1'b0}};
                r_out_resp[p*2 +: 2]            <= 2'd0;
                r_out_data[p*DATA_W +: DATA_W]  <= {DATA_W{1'b0}};
                r_out_tag[p*TAG_W +: TAG_W]     <= {TAG_W{1'b0}};
            end else begin
                if (w_capture[p]) begin
                    r_cap_cmd[p] <= bus.req_cmd_in[p*CMD_W +: CMD_W];
                    r_cap_op1[p] <= bus.req_data_in[p*DATA_W +: DATA_W];
                    r_cap_tag[p] <= bus.req_tag_in[p*TAG_W +: TAG_W];
                end
                if (w_push[p]) begin
                    r_fifo[p][r_wr_ptr[p]] <= w_push_entry[p];
                    r_wr_ptr[p]            <= r_wr_ptr[p] + TAG_W'(1);
                end
                if (w_pop[p]) begin
                    r_rd_ptr[p] <= r_rd_ptr[p] + TAG_W'(1);
                end
                r_count[p] <= r_count[p] + (TAG_W+1)'(w_push[p]) - (TAG_W+1)'(w_pop[p]);
                // Set is ORed after the clear so a same-edge reuse of a freed tag stays busy
                r_busy[p]  <= (r_busy[p] & ~w_clr_mask[p]) |
                              (w_push[p] ? (DEPTH'(1) << r_cap_tag[p]) : {DEPTH{1'b0}});
                if (w_rsp_hit[p]) begin
                    r_out_resp[p*2 +: 2]           <= bus.alu_rsp;
                    r_out_data[p*DATA_W +: DATA_W] <= bus.alu_rsp_data;
                    r_out_tag[p*TAG_W +: TAG_W]    <= bus.alu_rsp_tag;
                    if (w_err[p]) begin
                        r_err_pend[p] <= 1'b1;
                        r_err_tag[p]  <= r_cap_tag[p];
                    end
                end else if (r_err_pend[p]) begin
                    r_out_resp[p*2 +: 2]           <= 2'd2;
                    r_out_data[p*DATA_W +: DATA_W] <= {DATA_W{1'b0}};
                    r_out_tag[p*TAG_W +: TAG_W]    <= r_err_tag[p];
                    r_err_pend[p]                  <= 1'b0;
                end else if (w_err[p]) begin
                    r_out_resp[p*2 +: 2]           <= 2'd2;
                    r_out_data[p*DATA_W +: DATA_W] <= {DATA_W{1'b0}};
                    r_out_tag[p*TAG_W +: TAG_W]    <= r_cap_tag[p];
                end else begin
                    r_out_resp[p*2 +: 2]           <= 2'd0;
                    r_out_data[p*DATA_W +: DATA_W] <= {DATA_W{1'b0}};
                    r_out_tag[p*TAG_W +: TAG_W]    <= {TAG_W{1'b0}};
                end
            end
        end
    end

    // Registered ALU issue stage; holds while valid is not accepted
    always_ff @(posedge PClk) begin
        if (!reset) begin
            r_alu_valid <= 1'b0;
            r_alu_cmd   <= {CMD_W{1'b0}};
            r_alu_op1   <= {DATA_W{1'b0}};
            r_alu_op2   <= {DATA_W{1'b0}};
            r_alu_port  <= {PORT_W{1'b0}};
            r_alu_tag   <= {TAG_W{1'b0}};
            r_rr        <= {PORT_W{1'b0}};
        end else if (w_load && w_grant_vld) begin
            r_alu_valid <= 1'b1;
            r_alu_cmd   <= w_grant_entry[TAG_W+2*DATA_W +: CMD_W];
            r_alu_op1   <= w_grant_entry[TAG_W+DATA_W +: DATA_W];
            r_alu_op2   <= w_grant_entry[TAG_W +: DATA_W];
            r_alu_tag   <= w_grant_entry[0 +: TAG_W];
            r_alu_port  <= w_grant_idx;
            r_rr        <= (w_grant_idx == PORT_W'(NPORT-1)) ? {PORT_W{1'b0}} : (w_grant_idx + PORT_W'(1));
        end else if (w_load) begin
            r_alu_valid <= 1'b0;
            r_alu_cmd   <= {CMD_W{1'b0}};
            r_alu_op1   <= {DATA_W{1'b0}};
            r_alu_op2   <= {DATA_W{1'b0}};
            r_alu_port  <= {PORT_W{1'b0}};
            r_alu_tag   <= {TAG_W{1'b0}};
        end
    end

    assign bus.alu_valid = r_alu_valid;
    assign bus.alu_cmd   = r_alu_cmd;
    assign bus.alu_op1   = r_alu_op1;
    assign bus.alu_op2   = r_alu_op2;
    assign bus.alu_port  = r_alu_port;
    assign bus.alu_tag   = r_alu_tag;
    assign bus.out_resp  = r_out_resp;
    assign bus.out_data  = r_out_data;
    assign bus.out_tag   = r_out_tag;
endmodule

// File: tb/tb_calc_port_scheduler.sv
// Directed bench for calc_port_scheduler: latency, round-robin, back-pressure,
// error responses, busy tags and reset behaviour.
module tb_calc_port_scheduler;
    logic PClk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_err = 0;

    calc_port_scheduler_if bus ();
    calc_port_scheduler dut (.PClk(PClk), .reset(reset), .bus(bus));

    always #5 PClk = ~PClk;

    task automatic tick();
        @(posedge PClk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic drv(input int p, input logic [3:0] cmd, input logic [31:0] d, input logic [1:0] tag);
        bus.req_cmd_in[p*4 +: 4]   = cmd;
        bus.req_data_in[p*32 +: 32] = d;
        bus.req_tag_in[p*2 +: 2]   = tag;
    endtask

    task automatic rsp(input logic v, input int p, input logic [1:0] code, input logic [31:0] d, input logic [1:0] tag);
        bus.alu_rsp_valid = v;
        bus.alu_rsp_port  = 2'(p);
        bus.alu_rsp       = code;
        bus.alu_rsp_data  = d;
        bus.alu_rsp_tag   = tag;
    endtask

    task automatic chk_issue(input string name, input logic [3:0] cmd, input logic [31:0] op1,
                             input logic [31:0] op2, input logic [1:0] port, input logic [1:0] tag);
        chk({name, "_valid"}, 64'(bus.alu_valid), 64'd1);
        chk({name, "_cmd"},   64'(bus.alu_cmd),   64'(cmd));
        chk({name, "_op1"},   64'(bus.alu_op1),   64'(op1));
        chk({name, "_op2"},   64'(bus.alu_op2),   64'(op2));
        chk({name, "_port"},  64'(bus.alu_port),  64'(port));
        chk({name, "_tag"},   64'(bus.alu_tag),   64'(tag));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.req_cmd_in  = '0;
        bus.req_data_in = '0;
        bus.req_tag_in  = '0;
        rsp(1'b0, 0, 2'd0, 32'd0, 2'd0);
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        bus.alu_ready = 1'b1;
        do_reset();
        chk("rst_valid", 64'(bus.alu_valid), 64'd0);
        chk("rst_resp",  64'(bus.out_resp),  64'd0);
        chk("rst_data0", 64'(bus.out_data == '0), 64'd1);

        // Single request on port 1 (index 0): latency and response routing
        drv(0, 4'd1, 32'd5, 2'd2); tick();
        drv(0, 4'd0, 32'd7, 2'd0); tick();
        chk_issue("t1_issue", 4'd1, 32'd5, 32'd7, 2'd0, 2'd2);
        rsp(1'b1, 0, 2'd1, 32'd12, 2'd2); tick();
        rsp(1'b0, 0, 2'd0, 32'd0, 2'd0);
        chk("t1_valid_drop", 64'(bus.alu_valid), 64'd0);
        chk("t1_resp", 64'(bus.out_resp), 64'h01);
        chk("t1_data", 64'(bus.out_data[31:0]), 64'd12);
        chk("t1_tag",  64'(bus.out_tag), 64'h02);
        tick();
        chk("t1_resp_clear", 64'(bus.out_resp), 64'd0);
        chk("t1_data_clear", 64'(bus.out_data == '0), 64'd1);

        // Four simultaneous requests from pointer 0
        do_reset();
        for (int p = 0; p < 4; p++) drv(p, 4'd2, 32'(10 + p), 2'(p));
        tick();
        for (int p = 0; p < 4; p++) drv(p, 4'd0, 32'(100 + p), 2'd0);
        tick();
        chk_issue("t2_p0", 4'd2, 32'd10, 32'd100, 2'd0, 2'd0);
        tick();
        chk_issue("t2_p1", 4'd2, 32'd11, 32'd101, 2'd1, 2'd1);
        tick();
        chk_issue("t2_p2", 4'd2, 32'd12, 32'd102, 2'd2, 2'd2);
        tick();
        chk_issue("t2_p3", 4'd2, 32'd13, 32'd103, 2'd3, 2'd3);
        tick();
        chk("t2_idle", 64'(bus.alu_valid), 64'd0);
        drv(2, 4'd1, 32'd3, 2'd1); tick();
        drv(2, 4'd0, 32'd4, 2'd0); tick();
        chk_issue("t2_solo", 4'd1, 32'd3, 32'd4, 2'd2, 2'd1);
        drv(0, 4'd5, 32'd20, 2'd1);
        drv(3, 4'd5, 32'd30, 2'd1); tick();
        chk("t2_gap", 64'(bus.alu_valid), 64'd0);
        drv(0, 4'd0, 32'd21, 2'd0);
        drv(3, 4'd0, 32'd31, 2'd0); tick();
        chk_issue("t2_rr3", 4'd5, 32'd30, 32'd31, 2'd3, 2'd1);
        tick();
        chk_issue("t2_rr0", 4'd5, 32'd20, 32'd21, 2'd0, 2'd1);

        // Back-pressure with three queued requests
        do_reset();
        bus.alu_ready = 1'b0;
        drv(0, 4'd6, 32'h11, 2'd0);
        drv(1, 4'd6, 32'h22, 2'd0);
        drv(2, 4'd6, 32'h33, 2'd0); tick();
        drv(0, 4'd0, 32'h1, 2'd0);
        drv(1, 4'd0, 32'h2, 2'd0);
        drv(2, 4'd0, 32'h3, 2'd0); tick();
        for (int i = 0; i < 5; i++) begin
            chk_issue("t3_hold", 4'd6, 32'h11, 32'h1, 2'd0, 2'd0);
            if (i < 4) tick();
        end
        bus.alu_ready = 1'b1; tick();
        chk_issue("t3_p1", 4'd6, 32'h22, 32'h2, 2'd1, 2'd0);
        tick();
        chk_issue("t3_p2", 4'd6, 32'h33, 32'h3, 2'd2, 2'd0);
        tick();
        chk("t3_empty", 64'(bus.alu_valid), 64'd0);

        // Illegal command on port 4 (index 3)
        drv(3, 4'd3, 32'd9, 2'd1); tick();
        drv(3, 4'd0, 32'd8, 2'd0); tick();
        chk("t4_no_issue", 64'(bus.alu_valid), 64'd0);
        chk("t4_resp", 64'(bus.out_resp), 64'hC0 & 64'h80);
        chk("t4_tag",  64'(bus.out_tag), 64'h40);
        chk("t4_data", 64'(bus.out_data[127:96]), 64'd0);
        tick();
        chk("t4_resp_clear", 64'(bus.out_resp), 64'd0);

        // Busy tag on port 3 (index 2), then reuse after the result
        do_reset();
        drv(2, 4'd1, 32'h40, 2'd0); tick();
        drv(2, 4'd0, 32'h41, 2'd0); tick();
        chk_issue("t5_first", 4'd1, 32'h40, 32'h41, 2'd2, 2'd0);
        drv(2, 4'd2, 32'h50, 2'd0); tick();
        chk("t5_one_issue_a", 64'(bus.alu_valid), 64'd0);
        drv(2, 4'd0, 32'h51, 2'd0); tick();
        chk("t5_one_issue_b", 64'(bus.alu_valid), 64'd0);
        chk("t5_err_resp", 64'(bus.out_resp), 64'h20);
        chk("t5_err_tag",  64'(bus.out_tag), 64'h00);
        rsp(1'b1, 2, 2'd1, 32'h81, 2'd0); tick();
        rsp(1'b0, 0, 2'd0, 32'd0, 2'd0);
        chk("t5_ok_resp", 64'(bus.out_resp), 64'h10);
        chk("t5_ok_data", 64'(bus.out_data[95:64]), 64'h81);
        drv(2, 4'd1, 32'h60, 2'd0); tick();
        drv(2, 4'd0, 32'h61, 2'd0); tick();
        chk_issue("t5_reuse", 4'd1, 32'h60, 32'h61, 2'd2, 2'd0);

        // Error collides with an ALU result on port 2 (index 1): result first
        drv(1, 4'd1, 32'h70, 2'd0); tick();
        drv(1, 4'd0, 32'h71, 2'd0); tick();
        chk_issue("t5_p1", 4'd1, 32'h70, 32'h71, 2'd1, 2'd0);
        drv(1, 4'd7, 32'h0, 2'd3); tick();
        drv(1, 4'd0, 32'h0, 2'd0);
        rsp(1'b1, 1, 2'd1, 32'h5, 2'd0); tick();
        rsp(1'b0, 0, 2'd0, 32'd0, 2'd0);
        chk("t5_win_resp", 64'(bus.out_resp), 64'h04);
        chk("t5_win_data", 64'(bus.out_data[63:32]), 64'h5);
        tick();
        chk("t5_late_err", 64'(bus.out_resp), 64'h08);
        chk("t5_late_tag", 64'(bus.out_tag), 64'h0C);
        tick();
        chk("t5_err_clear", 64'(bus.out_resp), 64'd0);

        // Reset mid-OPND2 with the issue stage stalled
        bus.alu_ready = 1'b0;
        drv(0, 4'd1, 32'h90, 2'd1); tick();
        drv(0, 4'd0, 32'h91, 2'd0);
        drv(3, 4'd2, 32'hA0, 2'd2); tick();
        chk_issue("t6_held", 4'd1, 32'h90, 32'h91, 2'd0, 2'd1);
        reset = 1'b0;
        drv(3, 4'd0, 32'hA1, 2'd0);
        rsp(1'b1, 0, 2'd1, 32'h77, 2'd1); tick();
        chk("t6_valid", 64'(bus.alu_valid), 64'd0);
        chk("t6_cmd",   64'(bus.alu_cmd),   64'd0);
        chk("t6_op1",   64'(bus.alu_op1),   64'd0);
        chk("t6_op2",   64'(bus.alu_op2),   64'd0);
        chk("t6_tag",   64'(bus.alu_tag),   64'd0);
        chk("t6_resp",  64'(bus.out_resp),  64'd0);
        chk("t6_data",  64'(bus.out_data == '0), 64'd1);
        reset = 1'b1; tick();
        rsp(1'b0, 0, 2'd0, 32'd0, 2'd0);
        chk("t6_stale_resp", 64'(bus.out_resp), 64'd0);
        chk("t6_stale_data", 64'(bus.out_data == '0), 64'd1);
        chk("t6_no_issue",   64'(bus.alu_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
